// File: rtl/nclic_dispatch.sv
// nclic_dispatch: interrupt arbitration and dispatch scheduler for the nested CLIC.
// Picks the highest-priority pending+enabled source above the running level,
// requests the core, pulses a pending-clear on acceptance, and tracks handler
// nesting with a small stack of saved priority levels.
module nclic_dispatch #(
  parameter int NoInterrupts = 8,
  parameter int PrioWidth    = 3,
  parameter int StackDepth   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NoInterrupts-1:0]              i_pend,
  input  logic [NoInterrupts-1:0]              i_enable,
  input  logic [NoInterrupts*PrioWidth-1:0]    i_prio,
  input  logic                                 i_irq_take,
  input  logic                                 i_mret,
  output logic                                 o_irq_req,
  output logic [$clog2(NoInterrupts)-1:0]      o_irq_id,
  output logic [PrioWidth-1:0]                 o_irq_prio,
  output logic [NoInterrupts-1:0]              o_clear_pend,
  output logic [PrioWidth-1:0]                 o_cur_prio,
  output logic [$clog2(StackDepth+1)-1:0]      o_nest_depth
);

  localparam int IW = $clog2(NoInterrupts);
  localparam int DW = $clog2(StackDepth+1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [IW-1:0]           id_q, id_d;
  logic [PrioWidth-1:0]    prio_q, prio_d;
  logic [NoInterrupts-1:0] clear_q, clear_d;
  logic [PrioWidth-1:0]    cur_prio_q, cur_prio_d;
  logic [DW-1:0]           depth_q, depth_d;
  logic [PrioWidth-1:0]    stack_q [StackDepth];
  logic [PrioWidth-1:0]    stack_d [StackDepth];

  logic                    cand_valid;
  logic [IW-1:0]           cand_id;
  logic [PrioWidth-1:0]    cand_prio;
  logic [PrioWidth-1:0]    stack_top;
  logic                    take;
  logic                    pop;

  // Arbitration: highest priority among eligible sources, lowest id wins ties.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand_valid = 1'b0;
    cand_id    = '0;
    cand_prio  = '0;
    for (int k = 0; k < NoInterrupts; k++) begin
      if (i_pend[k] && i_enable[k] &&
          (i_prio[k*PrioWidth +: PrioWidth] > cur_prio_q) &&
          (depth_q < DW'(StackDepth)) &&
          (!cand_valid || (i_prio[k*PrioWidth +: PrioWidth] > cand_prio))) begin
        cand_valid = 1'b1;
        cand_id    = IW'(k);
        cand_prio  = i_prio[k*PrioWidth +: PrioWidth];
      end
    end
  end

  // Saved level on top of the nesting stack (entry depth-1).
  always_comb begin
    stack_top = '0;
    for (int k = 0; k < StackDepth; k++) begin
      if (DW'(k + 1) == depth_q) stack_top = stack_q[k];
    end
  end

  assign take = (state_q == REQ) && i_irq_take;
  assign pop  = i_mret && (depth_q != '0);

  // Next-state: nesting stack update and request FSM.
  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    id_d       = id_q;
    prio_d     = prio_q;
    clear_d    = '0;
    cur_prio_d = cur_prio_q;
    depth_d    = depth_q;
    stack_d    = stack_q;

    // Pop-then-push on a simultaneous take and mret puts the popped level
    // straight back, so only the running level changes.
    if (pop && take) begin
      cur_prio_d = prio_q;
    end else if (pop) begin
      cur_prio_d = stack_top;
      depth_d    = depth_q - DW'(1);
    end else if (take) begin
      for (int k = 0; k < StackDepth; k++) begin
        if (DW'(k) == depth_q) stack_d[k] = cur_prio_q;
      end
      cur_prio_d = prio_q;
      depth_d    = depth_q + DW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cand_valid) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = cand_id;
          prio_d  = cand_prio;
        end
      end
      REQ: begin
        if (take) begin
          state_d       = ACK;
          clear_d[id_q] = 1'b1;
        end else if (cand_valid) begin
          req_d  = 1'b1;
          id_d   = cand_id;
          prio_d = cand_prio;
        end else begin
          state_d = IDLE;
        end
      end
      // One-cycle bubble so the pending clear lands before re-arbitration.
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the stack is small and must read as cleared after reset, so it is reset like any register.
      state_q    <= IDLE;
      req_q      <= 1'b0;
      id_q       <= '0;
      prio_q     <= '0;
      clear_q    <= '0;
      cur_prio_q <= '0;
      depth_q    <= '0;
      for (int k = 0; k < StackDepth; k++) stack_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      req_q      <= req_d;
      id_q       <= id_d;
      prio_q     <= prio_d;
      clear_q    <= clear_d;
      cur_prio_q <= cur_prio_d;
      depth_q    <= depth_d;
      stack_q    <= stack_d;
    end
  end

  assign o_irq_req    = req_q;
  assign o_irq_id     = id_q;
  assign o_irq_prio   = prio_q;
  assign o_clear_pend = clear_q;
  assign o_cur_prio   = cur_prio_q;
  assign o_nest_depth = depth_q;

endmodule
